// File: rtl/delay_pipe_rr_sched_if.sv
// delay_pipe_rr_sched_if: requester-side and consumer-side signals of the shared delay pipe.
interface delay_pipe_rr_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
);
    logic [NREQ-1:0]              req;
    logic [NREQ*WIDTH-1:0]        req_data;
    logic [NREQ-1:0]              gnt;
    logic                         flush;
    logic                         out_valid;
    logic [$clog2(NREQ)-1:0]      out_id;
    logic [WIDTH-1:0]             out_data;
    logic                         out_ready;
    logic [$clog2(DEPTH+1)-1:0]   occupancy;
    modport master (
        output req, req_data, flush, out_ready,
        input  gnt, out_valid, out_id, out_data, occupancy
    );
    modport slave (
        input  req, req_data, flush, out_ready,
        output gnt, out_valid, out_id, out_data, occupancy
    );
endinterface

// File: rtl/delay_pipe_rr_sched.sv
// delay_pipe_rr_sched: round-robin arbiter feeding a fixed-latency pipe that carries data and requester ID.
module delay_pipe_rr_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input logic                    clk,
    input logic                    rstn,
    delay_pipe_rr_sched_if.slave   bus
);
    localparam int IW = $clog2(NREQ);
    localparam int OW = $clog2(DEPTH+1);
    logic [IW-1:0]    r_ptr;
    logic             r_vld  [DEPTH];
    logic [IW-1:0]    r_id   [DEPTH];
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [OW-1:0]    r_occ;
    logic             w_stall, w_any, w_go;
    logic [IW-1:0]    w_idx, w_cand;
    logic [OW-1:0]    w_occ_nxt;
    assign w_stall = r_vld[DEPTH-1] & ~bus.out_ready;
    // Scan from the far end back toward ptr so the closest requester is the last one written.
    always_comb begin
        w_any  = 1'b0;
        w_idx  = '0;
        w_cand = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            w_cand = IW'((int'(r_ptr) + k) % NREQ);
            if (bus.req[w_cand]) begin
                w_any = 1'b1;
                w_idx = w_cand;
            end
        end
    end
    assign w_go    = w_any & ~w_stall & ~bus.flush & rstn;
    assign bus.gnt = w_go ? (NREQ'(1) << w_idx) : '0;
    always_comb begin
        w_occ_nxt = OW'(w_go);
        for (int k = 0; k < DEPTH-1; k++)
            w_occ_nxt = w_occ_nxt + OW'(r_vld[k]);
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
            r_occ <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_vld[k]  <= 1'b0;
                r_id[k]   <= '0;
                r_data[k] <= '0;
            end
        end else if (bus.flush) begin
            r_occ <= '0;
            for (int k = 0; k < DEPTH; k++)
                r_vld[k] <= 1'b0;
        end else if (!w_stall) begin
            r_vld[0]  <= w_go;
            r_id[0]   <= w_idx;
            r_data[0] <= bus.req_data[w_idx*WIDTH +: WIDTH];
            for (int k = 1; k < DEPTH; k++) begin
                r_vld[k]  <= r_vld[k-1];
                r_id[k]   <= r_id[k-1];
                r_data[k] <= r_data[k-1];
            end
            r_occ <= w_occ_nxt;
            if (w_go)
                r_ptr <= (int'(w_idx) == NREQ-1) ? '0 : w_idx + 1'b1;
        end
    end
    assign bus.out_valid = r_vld[DEPTH-1];
    assign bus.out_id    = r_id[DEPTH-1];
    assign bus.out_data  = r_data[DEPTH-1];
    assign bus.occupancy = r_occ;
endmodule

// File: tb/tb_delay_pipe_rr_sched.sv
// tb_delay_pipe_rr_sched: randomized requesters and consumer against a queue-based model of the scheduler.
module tb_delay_pipe_rr_sched;
    localparam int NREQ  = 4;
    localparam int W     = 8;
    localparam int DEPTH = 2;
    typedef struct {
        int id;
        int data;
        int g;
    } ent_t;
    logic clk = 1'b0;
    logic rstn;
    delay_pipe_rr_sched_if #(.NREQ(NREQ), .WIDTH(W), .DEPTH(DEPTH)) bus ();
    delay_pipe_rr_sched #(.NREQ(NREQ), .WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    ent_t q[$];
    int adv = 0;
    int ptr = 0;
    logic [NREQ-1:0] r = '0;
    logic [W-1:0]    dat [NREQ];
    logic [NREQ-1:0] last_gnt = '0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic apply();
        for (int i = 0; i < NREQ; i++)
            bus.req_data[i*W +: W] = dat[i];
        bus.req = r;
    endtask
    task automatic step(input int preq, input int prdy, input int pfl);
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (r[i] && last_gnt[i]) r[i] = 1'b0;
            if (!r[i] && $urandom_range(99) < preq) begin
                r[i]   = 1'b1;
                dat[i] = W'($urandom);
            end
        end
        apply();
        bus.out_ready = $urandom_range(99) < prdy;
        bus.flush     = $urandom_range(99) < pfl;
    endtask
    initial forever begin
        @(negedge clk);
        last_gnt = bus.gnt;
    end
    // Grant prediction: first pending requester at or after ptr, unless stalled or flushing.
    int exp_g, sel, cand;
    bit stall;
    initial forever begin
        @(negedge clk);
        if (!rstn) begin
            chk("gnt_in_reset", 32'(bus.gnt), 0);
            ptr = 0;
        end else begin
            stall = q.size() > 0 && adv - q[0].g == DEPTH && !bus.out_ready;
            exp_g = 0;
            sel   = 0;
            if (!stall && !bus.flush)
                for (int k = 0; k < NREQ; k++) begin
                    cand = (ptr + k) % NREQ;
                    if (bus.req[cand]) begin
                        exp_g = 1 << cand;
                        sel   = cand;
                        break;
                    end
                end
            chk("gnt", 32'(bus.gnt), exp_g);
            if (exp_g != 0) begin
                q.push_back('{sel, int'(bus.req_data[sel*W +: W]), adv});
                ptr = (sel + 1) % NREQ;
            end
        end
    end
    // Output monitor: the oldest entry must appear exactly DEPTH advancing edges after its grant.
    bit due;
    int n_in;
    initial forever begin
        @(negedge clk);
        #1;
        if (!rstn) begin
            q.delete();
            chk("out_valid_in_reset", 32'(bus.out_valid), 0);
            chk("occupancy_in_reset", 32'(bus.occupancy), 0);
        end else begin
            due  = q.size() > 0 && adv - q[0].g == DEPTH;
            n_in = 0;
            foreach (q[j]) if (adv - q[j].g >= 1) n_in++;
            chk("out_valid", 32'(bus.out_valid), 32'(due));
            if (bus.out_valid && due) begin
                chk("out_id", 32'(bus.out_id), q[0].id);
                chk("out_data", 32'(bus.out_data), q[0].data);
            end
            chk("occupancy", 32'(bus.occupancy), n_in);
            if (bus.flush) q.delete();
            else if (!(due && !bus.out_ready)) begin
                if (due) void'(q.pop_front());
                adv++;
            end
        end
    end
    initial begin
        rstn          = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) dat[i] = '0;
        apply();
        repeat (3) @(posedge clk);
        #1;
        rstn   = 1'b1;
        r[2]   = 1'b1;
        dat[2] = 8'hA5;
        apply();
        repeat (6) step(0, 100, 0);
        repeat (8) step(100, 100, 0);
        repeat (400) step(40, 75, 4);
        repeat (6) step(100, 0, 0);
        #2;
        chk("occupancy_full", 32'(bus.occupancy), DEPTH);
        chk("out_valid_stalled", 32'(bus.out_valid), 1);
        rstn = 1'b0;
        #1;
        chk("gnt_async_reset", 32'(bus.gnt), 0);
        chk("out_valid_async_reset", 32'(bus.out_valid), 0);
        chk("occupancy_async_reset", 32'(bus.occupancy), 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (300) step(30, 80, 3);
        repeat (2*DEPTH + 4) step(0, 100, 0);
        @(negedge clk);
        #2;
        chk("drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
